result_writeback_arbiter: RTL and testbench

Shares the single result-memory write port among the four processing units (PUs) fed by the main control unit. It accepts finished dot-product results tagged with their row/column index, grants them round-robin, and forms the linear result address. It counts completed elements and signals completion of the whole result matrix to the main control unit, which then updates the status register.

---
 rtl/coproc_pkg.sv | 19 +
 rtl/rr_arbiter_4.sv | 43 ++++
 rtl/result_writeback_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_result_writeback_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: write-back FSM states, i_Config field positions, PU count.
package coproc_pkg;

    localparam int NUM_PU       = 4;
    localparam int CFG_FIELD_W  = 8;
    localparam int CFG_ROWS_LSB = 24;
    localparam int CFG_COLS_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_t;

    function automatic logic [CFG_FIELD_W-1:0] cfg_field(input logic [31:0] cfg, input int lsb);
        return cfg[lsb +: CFG_FIELD_W];
    endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: pointer register plus one-hot grant search starting after the last winner.
module rr_arbiter_4
    import coproc_pkg::*;
(
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [NUM_PU-1:0] i_Request,
    input  logic              i_Enable,
    output logic [NUM_PU-1:0] o_Grant
);

    logic [1:0] r_ptr;
    logic [1:0] w_grant_idx;
    logic       w_found;

    // Offset NUM_PU wraps to the pointer itself, so the last winner is searched last.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = r_ptr;
        for (int off = 1; off <= NUM_PU; off++) begin
            if (!w_found && i_Request[2'(r_ptr + 2'(off))]) begin
                w_found     = 1'b1;
                w_grant_idx = 2'(r_ptr + 2'(off));
            end
        end
    end

    always_comb begin
        o_Grant = '0;
        if (i_Enable && w_found) begin
            o_Grant[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_ptr <= 2'(NUM_PU - 1);
        end else if (i_Enable && w_found) begin
            r_ptr <= w_grant_idx;
        end
    end

endmodule

// File: rtl/result_writeback_arbiter.sv
// Shares the result-memory write port among the PUs, forms row*C+col addresses and signals completion.
// Optional RESULT_BOUNDS_CHECK_EN: drop out-of-range results and raise a sticky o_Error.
module result_writeback_arbiter #(
    parameter int                NUM_PU    = 4,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic [31:0]              i_Config,
    input  logic                     i_Start,
    input  logic [NUM_PU-1:0]        i_Result_Valid,
    input  logic [NUM_PU*DATA_W-1:0] i_Result_Data,
    input  logic [NUM_PU*8-1:0]      i_Result_Row,
    input  logic [NUM_PU*8-1:0]      i_Result_Col,
    output logic [NUM_PU-1:0]        o_Grant,
    output logic                     o_Mem_Write_Enable,
    output logic [ADDR_W-1:0]        o_Mem_Address,
    output logic [DATA_W-1:0]        o_Mem_Data,
    input  logic                     i_Mem_Ready,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Error
);
    import coproc_pkg::*;

    wb_state_t         r_state;
    logic [7:0]        r_rows;
    logic [7:0]        r_cols;
    logic [15:0]       r_count;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_busy;
    logic              r_done;

    logic [7:0]        w_pu_row  [NUM_PU];
    logic [7:0]        w_pu_col  [NUM_PU];
    logic [DATA_W-1:0] w_pu_data [NUM_PU];
    logic [NUM_PU-1:0] w_grant;
    logic [7:0]        w_sel_row;
    logic [7:0]        w_sel_col;
    logic [DATA_W-1:0] w_sel_data;
    logic [7:0]        w_cfg_rows;
    logic [7:0]        w_cfg_cols;
    logic [15:0]       w_total;
    logic [15:0]       w_prod;
    logic [ADDR_W-1:0] w_addr;
    logic              w_accept;
    logic              w_last;
    logic              w_arb_en;
    logic              w_in_bounds;
    logic              w_load;
    logic              w_unused_cfg;

    for (genvar gi = 0; gi < NUM_PU; gi++) begin : g_pu
        assign w_pu_row[gi]  = i_Result_Row[gi*8 +: 8];
        assign w_pu_col[gi]  = i_Result_Col[gi*8 +: 8];
        assign w_pu_data[gi] = i_Result_Data[gi*DATA_W +: DATA_W];
    end

    assign w_cfg_rows   = cfg_field(i_Config, CFG_ROWS_LSB);
    assign w_cfg_cols   = cfg_field(i_Config, CFG_COLS_LSB);
    assign w_unused_cfg = ^i_Config[23:8];

    // The output register is emptied every cycle the memory is ready, so i_Mem_Ready alone gates loading.
    assign w_accept = r_wen && i_Mem_Ready;
    assign w_total  = {8'd0, r_rows} * {8'd0, r_cols};
    assign w_last   = (r_state == ST_RUN) && w_accept && ((r_count + 16'd1) == w_total);
    assign w_arb_en = (r_state == ST_RUN) && i_Mem_Ready && !w_last;

    rr_arbiter_4 u_arb (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Request (i_Result_Valid),
        .i_Enable  (w_arb_en),
        .o_Grant   (w_grant)
    );

    always_comb begin
        w_sel_row  = '0;
        w_sel_col  = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            if (w_grant[k]) begin
                w_sel_row  = w_pu_row[k];
                w_sel_col  = w_pu_col[k];
                w_sel_data = w_pu_data[k];
            end
        end
    end

    assign w_prod = {8'd0, w_sel_row} * {8'd0, r_cols};
    assign w_addr = BASE_ADDR + ADDR_W'(w_prod) + ADDR_W'(w_sel_col);

`ifdef RESULT_BOUNDS_CHECK_EN
    logic r_error;

    assign w_in_bounds = (w_sel_row < r_rows) && (w_sel_col < r_cols);

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_error <= 1'b0;
        end else if (r_state == ST_IDLE && i_Start) begin
            r_error <= 1'b0;
        end else if ((|w_grant) && !w_in_bounds) begin
            r_error <= 1'b1;
        end
    end

    assign o_Error = r_error;
`else
    assign w_in_bounds = 1'b1;
    assign o_Error     = 1'b0;
`endif

    assign w_load = (|w_grant) && w_in_bounds;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state <= ST_IDLE;
            r_rows  <= '0;
            r_cols  <= '0;
            r_count <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_Start) begin
                        r_rows  <= w_cfg_rows;
                        r_cols  <= w_cfg_cols;
                        r_count <= '0;
                        if (w_cfg_rows == 8'd0 || w_cfg_cols == 8'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_count <= r_count + 16'd1;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Entered with r_done low only for empty matrices, which spend one extra cycle here.
                    r_done <= !r_done;
                    if (r_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_load) begin
                r_wen  <= 1'b1;
                r_addr <= w_addr;
                r_data <= w_sel_data;
            end else if (w_accept) begin
                r_wen <= 1'b0;
            end
        end
    end

    assign o_Grant            = w_grant;
    assign o_Mem_Write_Enable = r_wen;
    assign o_Mem_Address      = r_addr;
    assign o_Mem_Data         = r_data;
    assign o_Busy             = r_busy;
    assign o_Done             = r_done;

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Randomized scoreboard bench for result_writeback_arbiter: PU drivers feed elements, a negedge monitor checks writes.
`timescale 1ns/1ps
module tb_result_writeback_arbiter;

    localparam int NPU = 4;
    localparam int DW  = 32;
    localparam int AW  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       i_Config = '0;
    logic              i_Start = 1'b0;
    logic [NPU-1:0]    i_Result_Valid = '0;
    logic [NPU*DW-1:0] i_Result_Data = '0;
    logic [NPU*8-1:0]  i_Result_Row = '0;
    logic [NPU*8-1:0]  i_Result_Col = '0;
    logic              i_Mem_Ready = 1'b1;
    logic [NPU-1:0]    o_Grant;
    logic              o_Mem_Write_Enable;
    logic [AW-1:0]     o_Mem_Address;
    logic [DW-1:0]     o_Mem_Data;
    logic              o_Busy;
    logic              o_Done;
    logic              o_Error;

    always #5 clk = ~clk;

    result_writeback_arbiter dut (
        .i_Clock            (clk),
        .i_Reset            (rst_n),
        .i_Config           (i_Config),
        .i_Start            (i_Start),
        .i_Result_Valid     (i_Result_Valid),
        .i_Result_Data      (i_Result_Data),
        .i_Result_Row       (i_Result_Row),
        .i_Result_Col       (i_Result_Col),
        .o_Grant            (o_Grant),
        .o_Mem_Write_Enable (o_Mem_Write_Enable),
        .o_Mem_Address      (o_Mem_Address),
        .o_Mem_Data         (o_Mem_Data),
        .i_Mem_Ready        (i_Mem_Ready),
        .o_Busy             (o_Busy),
        .o_Done             (o_Done),
        .o_Error            (o_Error)
    );

    typedef struct packed {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [31:0] data;
    } elem_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    elem_t pu_q [NPU][$];
    wr_t   exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_run = 0;
    int last_acc_cyc = -100;
    int start_cyc = -100;
    int done_cnt = 0;
    int exp_total = 0;
    int mon_idx;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected write by address on each memory accept and checks completion timing.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (i_Start) start_cyc = cyc;
            if (cyc == start_cyc + 1) check("busy_after_start", o_Busy, (exp_total != 0));
            if (prev_hold) begin
                check("bp_wen_hold", o_Mem_Write_Enable, 1);
                check("bp_addr_hold", o_Mem_Address, prev_addr);
                check("bp_data_hold", o_Mem_Data, prev_data);
            end
            prev_hold = o_Mem_Write_Enable && !i_Mem_Ready;
            prev_addr = o_Mem_Address;
            prev_data = o_Mem_Data;
            if (o_Mem_Write_Enable && i_Mem_Ready) begin
                mon_idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (mon_idx < 0 && exp_q[i].addr == o_Mem_Address) mon_idx = i;
                check("write_addr_known", (mon_idx >= 0), 1);
                if (mon_idx >= 0) begin
                    check("write_data", o_Mem_Data, exp_q[mon_idx].data);
                    exp_q.delete(mon_idx);
                end
                acc_run++;
                last_acc_cyc = cyc;
                $display("write addr=0x%04h data=0x%08h", o_Mem_Address, o_Mem_Data);
            end
            if (o_Done) begin
                done_cnt++;
                check("done_elem_count", acc_run, exp_total);
                check("busy_low_at_done", o_Busy, 0);
                if (exp_total > 0) check("done_latency", cyc - last_acc_cyc, 1);
                else               check("zero_done_latency", cyc - start_cyc, 2);
            end
        end
    end

    task automatic present(input int k, input bit allow_idle);
        if (pu_q[k].size() == 0 || (allow_idle && $urandom_range(0, 3) == 0)) begin
            i_Result_Valid[k] = 1'b0;
        end else begin
            i_Result_Valid[k]      = 1'b1;
            i_Result_Row[k*8 +: 8] = pu_q[k][0].row;
            i_Result_Col[k*8 +: 8] = pu_q[k][0].col;
            i_Result_Data[k*DW +: DW] = pu_q[k][0].data;
        end
    endtask

    task automatic load(input int rows, input int cols, input int npus, input bit spread);
        elem_t e;
        int    k;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                e.row  = 8'(r);
                e.col  = 8'(c);
                e.data = $urandom;
                k = spread ? ((r * cols + c) % npus) : int'($urandom_range(0, npus - 1));
                pu_q[k].push_back(e);
                exp_q.push_back({16'(r * cols + c), e.data});
            end
        end
    endtask

    task automatic start_run(input logic [31:0] cfg, input bit allow_idle);
        @(posedge clk); #1;
        i_Config  = cfg;
        i_Start   = 1'b1;
        acc_run   = 0;
        exp_total = int'(cfg[31:24]) * int'(cfg[7:0]);
        for (int k = 0; k < NPU; k++) present(k, allow_idle);
        @(negedge clk);
        check("no_grant_in_idle", o_Grant, 0);
        @(posedge clk); #1;
        i_Start = 1'b0;
    endtask

    task automatic run_pus(input int max_cyc, input bit contention, input bit allow_idle,
                           input int bp_after, input int stop_after);
        int          n_grant = 0;
        int          bp_left = 0;
        bit          bp_used = 0;
        bit          fin = 0;
        int          d0 = done_cnt;
        logic [3:0]  g;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            @(negedge clk);
            g = o_Grant;
            check("grant_onehot", $onehot0(g), 1);
            check("grant_has_request", g & ~i_Result_Valid, 0);
            if (!i_Mem_Ready) check("no_grant_under_bp", g, 0);
            if (contention && n_grant < exp_total) check("contention_order", g, 4'b0001 << (n_grant % NPU));
            if (g != 0) n_grant++;
            @(posedge clk); #1;
            for (int k = 0; k < NPU; k++) begin
                if (g[k]) begin
                    if (pu_q[k].size() > 0) void'(pu_q[k].pop_front());
                    present(k, allow_idle);
                end else if (!i_Result_Valid[k]) begin
                    present(k, allow_idle);
                end
            end
            if (bp_after > 0 && !bp_used && acc_run >= bp_after) begin
                bp_used = 1;
                bp_left = 5;
            end
            i_Mem_Ready = (bp_left == 0);
            if (bp_left > 0) bp_left--;
            if (done_cnt > d0) fin = 1;
            if (stop_after > 0 && acc_run >= stop_after) fin = 1;
        end
        check("run_finished_in_budget", fin, 1);
    endtask

    task automatic finish_checks(input int d_before);
        int acc_snap;
        acc_snap = acc_run;
        repeat (3) @(posedge clk);
        #1;
        check("done_pulse_once", done_cnt - d_before, 1);
        check("nothing_lost", exp_q.size(), 0);
        check("no_write_after_done", acc_run, acc_snap);
        check("busy_idle", o_Busy, 0);
        $display("run done: %0d accepts, %0d expected", acc_run, exp_total);
    endtask

    int d_before;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_grant", o_Grant, 0);
        check("rst_wen", o_Mem_Write_Enable, 0);
        check("rst_addr", o_Mem_Address, 0);
        check("rst_data", o_Mem_Data, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_done", o_Done, 0);
        check("rst_error", o_Error, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: 4x4, every PU always requesting; grant order 0,1,2,3,...
        load(4, 4, 4, 1);
        d_before = done_cnt;
        start_run(32'h04040404, 0);
        run_pus(60, 1, 0, 0, 0);
        finish_checks(d_before);

        // Nominal 3x3 across three PUs, with random idle gaps
        load(3, 3, 3, 1);
        d_before = done_cnt;
        start_run(32'h03030303, 1);
        run_pus(100, 0, 1, 0, 0);
        finish_checks(d_before);
        check("no_error_nominal", o_Error, 0);

        // Backpressure for 5 cycles after the third accept
        load(3, 3, 4, 0);
        d_before = done_cnt;
        start_run(32'h03030303, 0);
        run_pus(100, 0, 0, 3, 0);
        finish_checks(d_before);

        // Zero dimension: done two cycles after start, no writes
        d_before = done_cnt;
        start_run(32'h00030300, 0);
        run_pus(10, 0, 0, 0, 0);
        finish_checks(d_before);
        check("zero_no_writes", acc_run, 0);

        // Reset mid-RUN after 4 writes
        load(3, 3, 4, 0);
        d_before = done_cnt;
        start_run(32'h03030303, 0);
        run_pus(60, 0, 0, 0, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_grant", o_Grant, 0);
        check("midrst_wen", o_Mem_Write_Enable, 0);
        check("midrst_addr", o_Mem_Address, 0);
        check("midrst_data", o_Mem_Data, 0);
        check("midrst_busy", o_Busy, 0);
        check("midrst_done", o_Done, 0);
        i_Result_Valid = '0;
        for (int k = 0; k < NPU; k++) pu_q[k].delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_done_from_reset", done_cnt, d_before);

        load(3, 3, 4, 0);
        d_before = done_cnt;
        start_run(32'h03030303, 1);
        run_pus(100, 0, 1, 0, 0);
        finish_checks(d_before);

`ifdef RESULT_BOUNDS_CHECK_EN
        // Out-of-range row is granted, dropped and flagged
        load(3, 3, 4, 0);
        pu_q[0].push_front({8'd3, 8'd1, 32'hDEAD_BEEF});
        d_before = done_cnt;
        start_run(32'h03030303, 0);
        run_pus(100, 0, 0, 0, 0);
        finish_checks(d_before);
        check("bounds_error_set", o_Error, 1);
        check("bounds_req_consumed", pu_q[0].size(), 0);
        start_run(32'h01010101, 0);
        check("bounds_error_cleared", o_Error, 0);
        load(1, 1, 1, 0);
        for (int k = 0; k < NPU; k++) present(k, 0);
        d_before = done_cnt;
        run_pus(30, 0, 0, 0, 0);
        finish_checks(d_before);
`else
        check("error_tied_low", o_Error, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
